// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares instruction-memory port 2 between the CPU core (pc+1 fetch and PST
// writes) and an external program loader stream. The loader gets bounded
// bursts. The CPU is stalled while it lacks the port, and one refetch cycle
// re-issues the CPU fetch address before the CPU resumes.

module imem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    localparam int BCNT_W   = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wen,
    input  logic              cpu_halted,
    output logic              cpu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic [BCNT_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        LD_OWN  = 2'd1,
        REFETCH = 2'd2
    } state_t;

    // beat_cnt saturates here while the CPU is halted.
    localparam logic [BCNT_W-1:0] MAX_CNT   = BCNT_W'(MAX_BURST);
    // The accept that hits this count is the last one of a bounded grant.
    localparam logic [BCNT_W-1:0] LIMIT_CNT = BCNT_W'(MAX_BURST - 1);

    state_t            r_state;
    logic [BCNT_W-1:0] r_beat_cnt;

    logic w_accept;
    logic w_limit;
    logic w_release;

    // In LD_OWN ld_ready is always 1, so every valid beat is an accept.
    assign w_accept  = (r_state == LD_OWN) && ld_valid;
    // A bounded grant ends on the accept that brings the count to MAX_BURST.
    assign w_limit   = (r_beat_cnt >= LIMIT_CNT) && !cpu_halted;
    // Leave LD_OWN on a bubble, on the last beat, or at the burst limit.
    // All three cases lead to a single REFETCH.
    assign w_release = !ld_valid || (w_accept && (ld_last || w_limit));

    // Ownership state and the per-grant beat counter.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CPU_OWN;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                CPU_OWN: begin
                    // A CPU write in this same cycle still goes to memory;
                    // ownership changes only at the next edge.
                    if (ld_valid) begin
                        r_state <= LD_OWN;
                    end
                end
                LD_OWN: begin
                    if (w_accept && (r_beat_cnt != MAX_CNT)) begin
                        r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
                    end
                    if (w_release) begin
                        r_state <= REFETCH;
                    end
                end
                REFETCH: begin
                    r_beat_cnt <= '0;
                    r_state    <= CPU_OWN;
                end
                default: begin
                    r_state    <= CPU_OWN;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    // Port-2 mux and handshake decode from the registered owner, gated by reset.
    // NOTE: every output gets a default at the top of always_comb, so no path
    // can leave a value unassigned and infer a latch.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = 1'b0;
        ld_ready  = 1'b0;
        cpu_stall = 1'b1;
        case (r_state)
            CPU_OWN: begin
                mem_wen   = cpu_wen;
                cpu_stall = 1'b0;
            end
            LD_OWN: begin
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                mem_wen   = ld_valid;
                ld_ready  = 1'b1;
            end
            REFETCH: begin
                // The sync-read RAM sees the CPU fetch address again, so the
                // pc+1 word is ready when the CPU resumes.
                mem_addr = cpu_addr;
            end
            default: begin
                mem_addr = cpu_addr;
            end
        endcase
        // While reset is high, nothing is written or accepted and the CPU holds.
        if (reset) begin
            mem_wen   = 1'b0;
            ld_ready  = 1'b0;
            cpu_stall = 1'b1;
        end
    end

    assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Directed stimulus for imem_port_arbiter. Each expected port-2 write is queued
// when its stimulus is issued. An independent monitor pops and compares the
// queue on every cycle in which the DUT asserts mem_wen.

module tb_imem_port_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 8;
    localparam int BCNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [15:0] CPU_PC = 16'h0300;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wen;
    logic              cpu_halted;
    logic              cpu_stall;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [BCNT_W-1:0] beat_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    imem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wen   (cpu_wen),
        .cpu_halted(cpu_halted),
        .cpu_stall (cpu_stall),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (mem_wen !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h wen %b expected no write",
                         mem_addr, mem_wdata, mem_wen);
            end else begin
                check("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic stall, input logic ready, input int bcnt);
        check({tag, "_stall"}, 32'(cpu_stall), 32'(stall));
        check({tag, "_ready"}, 32'(ld_ready), 32'(ready));
        check({tag, "_bcnt"},  32'(beat_cnt), 32'(bcnt));
    endtask

    task automatic set_beat(input logic [15:0] a, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = a ^ 16'h5A5A;
        ld_last  = last;
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
        logic [31:0] e;
        e = {a, d};
        exp_q.push_back(e);
    endtask

    // Continuous stream of n beats. The hand-computed grant sizes are g0..g2
    // (0 = unused). Each grant is a request cycle in CPU_OWN, the accepted
    // beats, and then one REFETCH cycle.
    task automatic run_stream(input string tag, input logic [15:0] base, input int n,
                              input logic halted, input int g0, input int g1, input int g2);
        int sizes[3];
        int idx;
        int bc;
        logic [15:0] a;
        sizes[0] = g0;
        sizes[1] = g1;
        sizes[2] = g2;
        idx = 0;
        cpu_halted = halted;
        for (int g = 0; g < 3; g++) begin
            if (sizes[g] != 0) begin
                a = base + 16'(idx);
                set_beat(a, idx == n - 1);
                #2;
                chk_ctl({tag, "_req"}, 1'b0, 1'b0, 0);
                next_cycle();
                for (int k = 0; k < sizes[g]; k++) begin
                    a = base + 16'(idx);
                    set_beat(a, idx == n - 1);
                    expect_write(a, a ^ 16'h5A5A);
                    #2;
                    bc = (k < MAX_BURST) ? k : MAX_BURST;
                    chk_ctl({tag, "_beat"}, 1'b1, 1'b1, bc);
                    next_cycle();
                    idx++;
                end
                if (idx < n) begin
                    a = base + 16'(idx);
                    set_beat(a, idx == n - 1);
                end else begin
                    ld_valid = 1'b0;
                    ld_last  = 1'b0;
                end
                #2;
                bc = (sizes[g] < MAX_BURST) ? sizes[g] : MAX_BURST;
                chk_ctl({tag, "_refetch"}, 1'b1, 1'b0, bc);
                check({tag, "_refetch_wen"},  32'(mem_wen),  32'h0);
                check({tag, "_refetch_addr"}, 32'(mem_addr), 32'(CPU_PC));
                next_cycle();
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #2;
        chk_ctl({tag, "_resume"}, 1'b0, 1'b0, 0);
        next_cycle();
        cpu_halted = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cpu_addr   = CPU_PC;
        cpu_wdata  = 16'h0000;
        cpu_wen    = 1'b1;   // must be gated off while reset is high
        cpu_halted = 1'b0;
        ld_valid   = 1'b1;   // must not be accepted while reset is high
        ld_addr    = 16'h0AAA;
        ld_data    = 16'h1111;
        ld_last    = 1'b0;

        // Reset: outputs are gated.
        next_cycle();
        next_cycle();
        #2;
        chk_ctl("reset", 1'b1, 1'b0, 0);
        check("reset_wen", 32'(mem_wen), 32'h0);
        next_cycle();
        reset    = 1'b0;
        cpu_wen  = 1'b0;
        ld_valid = 1'b0;
        #2;
        chk_ctl("post_reset", 1'b0, 1'b0, 0);
        next_cycle();

        // T1: CPU PST write passes straight through in CPU_OWN.
        cpu_addr  = 16'h0040;
        cpu_wdata = 16'hBEEF;
        cpu_wen   = 1'b1;
        expect_write(16'h0040, 16'hBEEF);
        #2;
        check("t1_addr",  32'(mem_addr),  32'h0040);
        check("t1_wdata", 32'(mem_wdata), 32'hBEEF);
        check("t1_wen",   32'(mem_wen),   32'h1);
        check("t1_stall", 32'(cpu_stall), 32'h0);
        next_cycle();
        cpu_wen  = 1'b0;
        cpu_addr = CPU_PC;
        next_cycle();

        // T2: three-beat transfer ending with ld_last.
        run_stream("t2", 16'h0100, 3, 1'b0, 3, 0, 0);

        // T3: 20 beats without halt -> grants of 8, 8, 4.
        run_stream("t3", 16'h1000, 20, 1'b0, 8, 8, 4);

        // T4: 20 beats while halted -> one grant, counter saturates at 8.
        run_stream("t4", 16'h2000, 20, 1'b1, 20, 0, 0);

        // T5: CPU write in the request cycle, 2 beats, then a bubble with a
        // stray ld_last that must be ignored.
        cpu_addr  = 16'h0060;
        cpu_wdata = 16'hC0DE;
        cpu_wen   = 1'b1;
        expect_write(16'h0060, 16'hC0DE);
        set_beat(16'h0200, 1'b0);
        #2;
        chk_ctl("t5_req", 1'b0, 1'b0, 0);
        next_cycle();
        cpu_wen  = 1'b0;
        cpu_addr = CPU_PC;
        for (int k = 0; k < 2; k++) begin
            set_beat(16'h0200 + 16'(k), 1'b0);
            expect_write(16'h0200 + 16'(k), (16'h0200 + 16'(k)) ^ 16'h5A5A);
            #2;
            chk_ctl("t5_beat", 1'b1, 1'b1, k);
            next_cycle();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b1;
        #2;
        chk_ctl("t5_bubble", 1'b1, 1'b1, 2);
        check("t5_bubble_wen", 32'(mem_wen), 32'h0);
        next_cycle();
        ld_last = 1'b0;
        #2;
        chk_ctl("t5_refetch", 1'b1, 1'b0, 2);
        next_cycle();
        #2;
        chk_ctl("t5_resume", 1'b0, 1'b0, 0);
        next_cycle();

        // T6: reset arrives during beat 3, which the loader then resends.
        set_beat(16'h0400, 1'b0);
        #2;
        chk_ctl("t6_req", 1'b0, 1'b0, 0);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            set_beat(16'h0400 + 16'(k), 1'b0);
            expect_write(16'h0400 + 16'(k), (16'h0400 + 16'(k)) ^ 16'h5A5A);
            #2;
            chk_ctl("t6_beat", 1'b1, 1'b1, k);
            next_cycle();
        end
        set_beat(16'h0402, 1'b1);
        reset = 1'b1;
        #2;
        chk_ctl("t6_reset", 1'b1, 1'b0, 2);
        check("t6_reset_wen", 32'(mem_wen), 32'h0);
        next_cycle();
        reset = 1'b0;
        #2;
        chk_ctl("t6_after_reset", 1'b0, 1'b0, 0);
        next_cycle();
        expect_write(16'h0402, 16'h0402 ^ 16'h5A5A);
        #2;
        chk_ctl("t6_resend", 1'b1, 1'b1, 0);
        next_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #2;
        chk_ctl("t6_refetch", 1'b1, 1'b0, 1);
        next_cycle();
        #2;
        chk_ctl("t6_resume", 1'b0, 1'b0, 0);
        next_cycle();
        next_cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
